// File: rtl/flex_down_timer.sv
// Programmable down-counting timer: prescaled ticks decrement count_out from load_val;
// expiry on a tick at zero either reloads (auto_reload) or parks in DONE.
module flex_down_timer #(
    parameter int SIZE          = 4,
    parameter int PRESCALE_SIZE = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clear,
    input  logic                     start,
    input  logic [SIZE-1:0]          load_val,
    input  logic                     auto_reload,
    input  logic [PRESCALE_SIZE-1:0] tick_div,
    input  logic                     pause,
    output logic [SIZE-1:0]          count_out,
    output logic                     busy,
    output logic                     expire_flag,
    output logic                     done,
    output logic [1:0]               state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    logic [PRESCALE_SIZE-1:0] prescale_cnt;
    logic                     active;
    logic                     tick;

    // >= rather than == so lowering tick_div mid-run ticks promptly instead of wrapping
    assign active    = (state == RUN) && !pause;
    assign tick      = active && (prescale_cnt >= tick_div);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            prescale_cnt <= '0;
            count_out    <= '0;
            busy         <= 1'b0;
            expire_flag  <= 1'b0;
            done         <= 1'b0;
        end else begin
            expire_flag <= 1'b0;
            if (clear) begin
                state        <= IDLE;
                prescale_cnt <= '0;
                count_out    <= '0;
                busy         <= 1'b0;
                done         <= 1'b0;
            end else if (start) begin
                state        <= RUN;
                prescale_cnt <= '0;
                count_out    <= load_val;
                busy         <= 1'b1;
                done         <= 1'b0;
            end else if (active) begin
                if (tick) begin
                    prescale_cnt <= '0;
                    if (count_out != '0) begin
                        count_out <= count_out - 1'b1;
                    end else begin
                        expire_flag <= 1'b1;
                        if (auto_reload) begin
                            count_out <= load_val;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end else begin
                    prescale_cnt <= prescale_cnt + 1'b1;
                end
            end
        end
    end

endmodule
